// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - per-cycle commit trace recorder with show-ahead drain FIFO
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CYC_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        pc,
    input  logic               reg_wrt,
    input  logic [3:0]         reg_dst,
    input  logic [15:0]        reg_data,
    input  logic               mem_rd,
    input  logic               mem_wrt,
    input  logic [15:0]        mem_addr,
    input  logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata,
    input  logic               hlt,
    input  logic               rd_en,
    output logic               rd_valid,
    output logic [3:0]         rd_flags,
    output logic [3:0]         rd_reg_dst,
    output logic [15:0]        rd_reg_data,
    output logic [15:0]        rd_mem_addr,
    output logic [15:0]        rd_mem_data,
    output logic [CYC_W-1:0]   rd_cycle,
    output logic [PTR_W:0]     count,
    output logic               full,
    output logic               overflow,
    output logic [15:0]        drop_count,
    output logic [CYC_W-1:0]   cycle_count,
    output logic [CYC_W-1:0]   inst_count,
    output logic               halted
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    // One FIFO slot: everything committed in a single cycle
    typedef struct packed {
        logic [3:0]       flags;     // {halt, store, load, reg}
        logic [3:0]       reg_dst;
        logic [15:0]      reg_data;
        logic [15:0]      mem_addr;  // pc for a halt-only entry
        logic [15:0]      mem_data;
        logic [CYC_W-1:0] cycle;
    } entry_t;

    // Storage is deliberately left out of reset; rd_valid qualifies it
    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      drop_count_q, drop_count_d;
    logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
    logic [CYC_W-1:0] inst_count_q, inst_count_d;
    logic             halted_q, halted_d;

    logic   ev;
    logic   capture;
    logic   pop;
    logic   push;
    logic   drop;
    logic   inst_commit;
    logic   full_w;
    entry_t new_entry;
    entry_t head;

    assign full_w = (count_q == DEPTH_CNT);

    // Decode this cycle's commit activity into capture / push / pop / drop
    always_comb begin
        ev          = reg_wrt | mem_rd | mem_wrt | hlt;
        capture     = ev & ~halted_q;
        // An empty FIFO never pops, so a same-cycle push cannot bypass
        pop         = rd_en & (count_q != '0);
        push        = capture & (~full_w | pop);
        drop        = capture & full_w & ~pop;
        inst_commit = ~halted_q & (hlt | reg_wrt | mem_wrt);
    end

    // Pack the cycle's activity into one entry; stores win the data field
    always_comb begin
        new_entry.flags    = {hlt, mem_wrt, mem_rd, reg_wrt};
        new_entry.reg_dst  = reg_wrt ? reg_dst  : 4'd0;
        new_entry.reg_data = reg_wrt ? reg_data : 16'd0;
        if (mem_rd | mem_wrt) begin
            new_entry.mem_addr = mem_addr;
        end else if (hlt) begin
            new_entry.mem_addr = pc;
        end else begin
            new_entry.mem_addr = 16'd0;
        end
        if (mem_wrt) begin
            new_entry.mem_data = mem_wdata;
        end else if (mem_rd) begin
            new_entry.mem_data = mem_rdata;
        end else begin
            new_entry.mem_data = 16'd0;
        end
        new_entry.cycle = cycle_count_q;
    end

    // Pointer and occupancy updates
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Drop accounting, counters and the sticky halt flag
    always_comb begin
        overflow_d    = overflow_q | drop;
        drop_count_d  = drop_count_q;
        cycle_count_d = cycle_count_q;
        inst_count_d  = inst_count_q;
        halted_d      = halted_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        if (!halted_q) begin
            cycle_count_d = cycle_count_q + CYC_W'(1);
        end
        if (inst_commit) begin
            inst_count_d = inst_count_q + CYC_W'(1);
        end
        // hlt implies ev, so a halt that reaches here is always captured
        if (capture && hlt) begin
            halted_d = 1'b1;
        end
    end

    // Control state register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            drop_count_q  <= '0;
            cycle_count_q <= '0;
            inst_count_q  <= '0;
            halted_q      <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            drop_count_q  <= drop_count_d;
            cycle_count_q <= cycle_count_d;
            inst_count_q  <= inst_count_d;
            halted_q      <= halted_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    // Show-ahead read port: head entry straight from storage
    always_comb begin
        head        = mem_q[rd_ptr_q];
        rd_valid    = (count_q != '0);
        rd_flags    = head.flags;
        rd_reg_dst  = head.reg_dst;
        rd_reg_data = head.reg_data;
        rd_mem_addr = head.mem_addr;
        rd_mem_data = head.mem_data;
        rd_cycle    = head.cycle;
    end

    assign count       = count_q;
    assign full        = full_w;
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;
    assign cycle_count = cycle_count_q;
    assign inst_count  = inst_count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - scoreboard bench for commit_trace_fifo
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;
    localparam int CYC_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [15:0]       pc = '0;
    logic              reg_wrt = 1'b0;
    logic [3:0]        reg_dst = '0;
    logic [15:0]       reg_data = '0;
    logic              mem_rd = 1'b0;
    logic              mem_wrt = 1'b0;
    logic [15:0]       mem_addr = '0;
    logic [15:0]       mem_wdata = '0;
    logic [15:0]       mem_rdata = '0;
    logic              hlt = 1'b0;
    logic              rd_en = 1'b0;
    logic              rd_valid;
    logic [3:0]        rd_flags;
    logic [3:0]        rd_reg_dst;
    logic [15:0]       rd_reg_data;
    logic [15:0]       rd_mem_addr;
    logic [15:0]       rd_mem_data;
    logic [CYC_W-1:0]  rd_cycle;
    logic [PTR_W:0]    count;
    logic              full;
    logic              overflow;
    logic [15:0]       drop_count;
    logic [CYC_W-1:0]  cycle_count;
    logic [CYC_W-1:0]  inst_count;
    logic              halted;

    always #5 clk = ~clk;

    commit_trace_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .reg_wrt(reg_wrt), .reg_dst(reg_dst), .reg_data(reg_data),
        .mem_rd(mem_rd), .mem_wrt(mem_wrt), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_flags(rd_flags),
        .rd_reg_dst(rd_reg_dst), .rd_reg_data(rd_reg_data),
        .rd_mem_addr(rd_mem_addr), .rd_mem_data(rd_mem_data),
        .rd_cycle(rd_cycle), .count(count), .full(full),
        .overflow(overflow), .drop_count(drop_count),
        .cycle_count(cycle_count), .inst_count(inst_count), .halted(halted)
    );

    typedef struct packed {
        logic [3:0]  flags;
        logic [3:0]  rdst;
        logic [15:0] rdat;
        logic [15:0] addr;
        logic [15:0] data;
        logic [31:0] cyc;
    } ent_t;

    // Reference model: expected entry queue plus architectural counters
    ent_t        exp_q[$];
    int          mcnt = 0;
    bit          m_halt = 0;
    bit          m_ovf = 0;
    int          m_drop = 0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_inst = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        chk("count", 32'(count), mcnt);
        chk("full", 32'(full), 32'(mcnt == DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(mcnt != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), m_drop);
        chk("cycle_count", cycle_count, m_cyc);
        chk("inst_count", inst_count, m_inst);
        chk("halted", 32'(halted), 32'(m_halt));
    endtask

    task automatic clear_model();
        exp_q.delete();
        mcnt   = 0;
        m_halt = 0;
        m_ovf  = 0;
        m_drop = 0;
        m_cyc  = '0;
        m_inst = '0;
    endtask

    task automatic drive_idle();
        reg_wrt = 0; mem_rd = 0; mem_wrt = 0; hlt = 0; rd_en = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_inst_count", inst_count, 0);
        chk("rst_halted", 32'(halted), 0);
    endtask

    // Apply one cycle of stimulus at a falling edge, model the coming rising edge
    task automatic step(input bit rw, input logic [3:0] rd, input logic [15:0] rdat,
                        input bit mr, input bit mw, input logic [15:0] ma,
                        input logic [15:0] wd, input logic [15:0] rdd,
                        input bit h, input logic [15:0] p, input bit re);
        ent_t e;
        bit   ev, cap, pp, ps;
        reg_wrt = rw; reg_dst = rd; reg_data = rdat;
        mem_rd = mr; mem_wrt = mw; mem_addr = ma; mem_wdata = wd; mem_rdata = rdd;
        hlt = h; pc = p; rd_en = re;
        ev  = rw | mr | mw | h;
        cap = ev && !m_halt;
        pp  = re && (mcnt > 0);
        ps  = cap && (mcnt < DEPTH || pp);
        if (ps) begin
            e.flags = {h, mw, mr, rw};
            e.rdst  = rw ? rd : 4'd0;
            e.rdat  = rw ? rdat : 16'd0;
            e.addr  = (mr || mw) ? ma : (h ? p : 16'd0);
            e.data  = mw ? wd : (mr ? rdd : 16'd0);
            e.cyc   = m_cyc;
            exp_q.push_back(e);
        end
        mcnt = mcnt + int'(ps) - int'(pp);
        if (cap && !ps) begin
            m_ovf = 1;
            if (m_drop < 16'hFFFF) m_drop++;
        end
        if (!m_halt) begin
            m_cyc = m_cyc + 1;
            if (h || rw || mw) m_inst = m_inst + 1;
            if (h) m_halt = 1;
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic rand_step(input int hlt_pct, input int re_pct);
        step($urandom_range(0, 99) < 40, 4'($urandom), 16'($urandom),
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
             16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 99) < hlt_pct, 16'($urandom),
             $urandom_range(0, 99) < re_pct);
    endtask

    task automatic idle_step(input bit re);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, re);
    endtask

    // Reset held from one falling edge to the next; no rising edge escapes it
    task automatic reset_aligned();
        drive_idle();
        rst_n = 0;
        #1;
        check_reset_values();
        clear_model();
        @(negedge clk);
        rst_n = 1;
    endtask

    // 30-unit reset off the clock grid; one idle rising edge follows release
    task automatic reset_async();
        drive_idle();
        #3;
        rst_n = 0;
        #1;
        check_reset_values();
        #29;
        rst_n = 1;
        clear_model();
        m_cyc = 1;
        @(negedge clk);
    endtask

    // Monitor: compare head entry against scoreboard whenever a pop is presented
    initial begin
        ent_t e, got;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && rd_valid && rd_en) begin
                got = {rd_flags, rd_reg_dst, rd_reg_data, rd_mem_addr, rd_mem_data, rd_cycle};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL entry: got %h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL entry: got %h expected %h", got, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        reset_aligned();

        // First register write lands with timestamp 0
        step(1, 4'd3, 16'h00AB, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("first_flags", 32'(rd_flags), 32'h1);
        chk("first_cycle", rd_cycle, 0);
        chk("first_reg_data", 32'(rd_reg_data), 32'h00AB);
        // Load with its register write forms one entry
        step(1, 4'd5, 16'h1111, 1, 0, 16'h0040, 0, 16'hBEEF, 0, 0, 0);
        for (int i = 0; i < 300; i++) rand_step(0, 60);
        for (int i = 0; i < 20; i++) idle_step(1);

        // Overflow: 18 pushes into 16 slots, then full push+pop
        reset_aligned();
        for (int i = 0; i < 18; i++) step(1, 4'(i), 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ovf_drop_count", 32'(drop_count), 2);
        chk("ovf_full", 32'(full), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'($urandom), 16'($urandom), 0, 0, 0, 1);
        chk("fullpp_count", 32'(count), 16);
        chk("fullpp_drop", 32'(drop_count), 2);
        for (int i = 0; i < 20; i++) idle_step(1);

        // Mid-drain asynchronous reset
        for (int i = 0; i < 8; i++) rand_step(0, 0);
        for (int i = 0; i < 8; i++) step(1, 4'(i), 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle_step(1);
        reset_async();

        // Halt: store, idle, halt; later activity is ignored
        reset_aligned();
        step(0, 0, 0, 0, 1, 16'h0010, 16'h1234, 0, 0, 0, 0);
        idle_step(0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0022, 0);
        for (int i = 0; i < 4; i++) step(1, 4'(i), 16'($urandom), 0, 0, 0, 0, 0, 0, 0, 0);
        chk("halt_cycle_frozen", cycle_count, 3);
        chk("halt_count", 32'(count), 2);
        for (int i = 0; i < 6; i++) idle_step(1);

        // Long random run with occasional halt
        reset_aligned();
        for (int i = 0; i < 300; i++) rand_step(0, 45);
        for (int i = 0; i < 300; i++) rand_step(1, 50);
        for (int i = 0; i < 20; i++) idle_step(1);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
